// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, F/D word layout,
// bubble/halt encodings and PC arithmetic.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  localparam logic [INSTR_W-1:0] OPC_NOP  = 16'h0800;
  localparam logic [INSTR_W-1:0] OPC_HALT = 16'hF000;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    inc_pc;
  } fd_word_t;

  // Sequential PC step; wraps 16'hFFFE -> 16'h0000.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(2);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface fetch_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_done;

  modport master (output imem_addr, output imem_rd, input imem_data, input imem_done);
  modport slave  (input imem_addr, input imem_rd, output imem_data, output imem_done);

endinterface

// File: rtl/fetch_hold_buf.sv
// Holds one fetched instruction/inc_pc pair while decode is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  fd_word_t d,
  output fd_word_t q
);

  fd_word_t word_q, word_d;

  // Clear wins so a redirect always discards a capture in the same cycle.
  always_comb begin
    word_d = word_q;
    if (clear)     word_d = '0;
    else if (load) word_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign q = word_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch-stage controller: owns the PC, issues variable-latency imem reads and
// produces the F/D word plus its load enable, with redirect flush and halt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = OPC_NOP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  fetch_if.master            imem,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    inc_pc,
  output logic               fd_en
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halt_pend_q, halt_pend_d;
  logic            buf_ld, buf_clr, take;
  logic            rd_busy;
  fd_word_t        buf_in, buf_q;

  assign buf_in  = '{instr: imem.imem_data, inc_pc: pc_next(pc_q)};
  assign rd_busy = (state_q == FETCH) || (state_q == WAIT) || (state_q == DRAIN);

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_ld),
    .clear (buf_clr),
    .d     (buf_in),
    .q     (buf_q)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    halt_pend_d    = halt_pend_q;
    buf_ld         = 1'b0;
    buf_clr        = 1'b0;
    take           = 1'b0;
    imem.imem_rd   = 1'b0;
    imem.imem_addr = pc_q;
    instr          = NOP_INSTR;
    inc_pc         = '0;
    fd_en          = !stall;

    case (state_q)
      FETCH: begin
        // A halt suppresses the request, so no read is left in flight.
        imem.imem_rd = redirect || !halt;
        if (halt)                state_d = HALTED;
        else if (imem.imem_done) take    = 1'b1;
        else                     state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_done) begin
          if (halt) state_d = HALTED;
          else      take    = 1'b1;
        end else if (halt) begin
          state_d     = DRAIN;
          halt_pend_d = 1'b1;
        end
      end
      HOLD: begin
        if (halt) begin
          state_d = HALTED;
          buf_clr = 1'b1;
        end else begin
          instr  = buf_q.instr;
          inc_pc = buf_q.inc_pc;
          if (!stall) begin
            pc_d    = pc_next(pc_q);
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (imem.imem_done) begin
          state_d     = (halt_pend_q || halt) ? HALTED : FETCH;
          halt_pend_d = 1'b0;
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase

    // Completed read: forward straight to F/D, or park it while decode stalls.
    if (take) begin
      if (!stall) begin
        instr   = imem.imem_data;
        inc_pc  = pc_next(pc_q);
        fd_en   = 1'b1;
        pc_d    = pc_next(pc_q);
        state_d = FETCH;
      end else begin
        buf_ld  = 1'b1;
        state_d = HOLD;
      end
    end

    if (redirect) begin
      pc_d        = redirect_pc;
      buf_ld      = 1'b0;
      buf_clr     = 1'b1;
      halt_pend_d = 1'b0;
      instr       = NOP_INSTR;
      inc_pc      = '0;
      fd_en       = 1'b1;
      state_d     = (rd_busy && !imem.imem_done) ? DRAIN : FETCH;
    end

    if (rst) begin
      imem.imem_rd = 1'b0;
      instr        = NOP_INSTR;
      inc_pc       = '0;
      fd_en        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halt_pend_q <= halt_pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes expected F/D loads
// and imem addresses; monitors pop and compare on every fd_en / imem_rd.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, halt;
  logic [15:0] redirect_pc;
  logic [15:0] instr, inc_pc;
  logic        fd_en;

  fetch_if imem_bus ();

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(OPC_NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem        (imem_bus),
    .instr       (instr),
    .inc_pc      (inc_pc),
    .fd_en       (fd_en)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory model: latency 'lat' cycles, lat==1 answers in the request cycle.
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [15:0] paddr = '0;
  int          rd_count = 0;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      16'h0200: return OPC_HALT;
      default:  return 16'h5A00 ^ a;
    endcase
  endfunction

  always_comb begin
    imem_bus.imem_done = 1'b0;
    imem_bus.imem_data = '0;
    if (pend) begin
      if (cnt == lat - 1) begin
        imem_bus.imem_done = 1'b1;
        imem_bus.imem_data = mem_val(paddr);
      end
    end else if (imem_bus.imem_rd && lat == 1) begin
      imem_bus.imem_done = 1'b1;
      imem_bus.imem_data = mem_val(imem_bus.imem_addr);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (pend) begin
      if (imem_bus.imem_done) pend <= 1'b0;
      else                    cnt  <= cnt + 1;
    end else if (imem_bus.imem_rd && !imem_bus.imem_done) begin
      pend  <= 1'b1;
      cnt   <= 1;
      paddr <= imem_bus.imem_addr;
    end
    if (!rst && imem_bus.imem_rd) rd_count <= rd_count + 1;
  end

  logic [31:0] exp_fd[$];
  logic [15:0] exp_addr[$];
  logic [31:0] mon_fd;
  logic [15:0] mon_addr;

  task automatic push_fd(input logic [15:0] i, input logic [15:0] p);
    exp_fd.push_back({i, p});
  endtask

  task automatic push_addr(input logic [15:0] a);
    exp_addr.push_back(a);
  endtask

  // Monitors: every F/D load and every imem request must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (fd_en) begin
        if (exp_fd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fd_load_unexpected: got instr %h inc_pc %h, expected no load", instr, inc_pc);
        end else begin
          mon_fd = exp_fd.pop_front();
          chk("fd_instr", instr, mon_fd[31:16]);
          chk("fd_inc_pc", inc_pc, mon_fd[15:0]);
        end
      end
      if (imem_bus.imem_rd) begin
        chk("rd_while_outstanding", 16'(pend), 16'h0);
        if (exp_addr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL imem_rd_unexpected: got addr %h, expected no request", imem_bus.imem_addr);
        end else begin
          mon_addr = exp_addr.pop_front();
          chk("imem_addr", imem_bus.imem_addr, mon_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rc0;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; lat = 1;
    tick(); tick(); #2;
    chk("rst_imem_rd", 16'(imem_bus.imem_rd), 16'h0);
    chk("rst_fd_en", 16'(fd_en), 16'h0);
    chk("rst_instr", instr, OPC_NOP);
    chk("rst_inc_pc", inc_pc, 16'h0000);
    chk("rst_pc", imem_bus.imem_addr, 16'h0000);

    // Zero-wait memory
    tick(); rst = 1'b0; push_addr(16'h0000); push_fd(16'h1111, 16'h0002); #2;
    chk("zw_fd_en", 16'(fd_en), 16'h1);
    tick(); push_addr(16'h0002); push_fd(16'h2222, 16'h0004);
    tick(); push_addr(16'h0004); push_fd(16'h3333, 16'h0006);

    // 3-cycle memory: two bubbles per instruction
    tick(); lat = 3; rc0 = rd_count; push_addr(16'h0006); push_fd(OPC_NOP, 16'h0000);
    tick(); push_fd(OPC_NOP, 16'h0000);
    tick(); push_fd(16'h5A06, 16'h0008);
    tick(); push_addr(16'h0008); push_fd(OPC_NOP, 16'h0000);
    tick(); push_fd(OPC_NOP, 16'h0000);
    tick(); push_fd(16'h5A08, 16'h000A);
    tick(); lat = 1;
    chk("lat3_rd_pulses", 16'(rd_count - rc0), 16'd2);
    push_addr(16'h000A); push_fd(16'h5A0A, 16'h000C);
    tick(); push_addr(16'h000C); push_fd(16'h5A0C, 16'h000E);
    tick(); push_addr(16'h000E); push_fd(16'h5A0E, 16'h0010);

    // Stall held 4 cycles on the fetch at 0x0010
    tick(); stall = 1'b1; push_addr(16'h0010); #2;
    chk("stall_cap_fd_en", 16'(fd_en), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      chk("hold_instr", instr, 16'h5A10);
      chk("hold_inc_pc", inc_pc, 16'h0012);
      chk("hold_fd_en", 16'(fd_en), 16'h0);
      chk("hold_pc", imem_bus.imem_addr, 16'h0010);
      chk("hold_imem_rd", 16'(imem_bus.imem_rd), 16'h0);
    end
    tick(); stall = 1'b0; push_fd(16'h5A10, 16'h0012); #2;
    chk("release_fd_en", 16'(fd_en), 16'h1);
    tick(); push_addr(16'h0012); push_fd(16'h5A12, 16'h0014); #2;
    chk("release_next_addr", imem_bus.imem_addr, 16'h0012);

    // Redirect while a read is in WAIT, with decode stalled
    tick(); lat = 3; push_addr(16'h0014); push_fd(OPC_NOP, 16'h0000);
    tick(); redirect = 1'b1; redirect_pc = 16'h0100; stall = 1'b1; push_fd(OPC_NOP, 16'h0000); #2;
    chk("redir_fd_en", 16'(fd_en), 16'h1);
    chk("redir_inc_pc", inc_pc, 16'h0000);
    tick(); redirect = 1'b0; #2;
    chk("drain_fd_en", 16'(fd_en), 16'h0);
    chk("drain_imem_rd", 16'(imem_bus.imem_rd), 16'h0);
    chk("drain_instr", instr, OPC_NOP);
    tick(); stall = 1'b0; lat = 1; push_addr(16'h0100); push_fd(16'h5B00, 16'h0102); #2;
    chk("redir_target_addr", imem_bus.imem_addr, 16'h0100);

    // Halt with simultaneous redirect: redirect wins
    tick(); halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    push_addr(16'h0102); push_fd(OPC_NOP, 16'h0000);
    tick(); halt = 1'b0; redirect = 1'b0; push_addr(16'h0200); push_fd(OPC_HALT, 16'h0202); #2;
    chk("halt_redir_addr", imem_bus.imem_addr, 16'h0200);

    // Halt alone
    tick(); halt = 1'b1; push_fd(OPC_NOP, 16'h0000); #2;
    chk("halt_imem_rd", 16'(imem_bus.imem_rd), 16'h0);
    tick(); halt = 1'b0; rc0 = rd_count;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      push_fd(OPC_NOP, 16'h0000); #2;
      chk("halted_imem_rd", 16'(imem_bus.imem_rd), 16'h0);
      chk("halted_pc", imem_bus.imem_addr, 16'h0202);
    end

    // Reset restarts at RESET_PC; then PC wrap at 0xFFFE
    tick(); rst = 1'b1; #2;
    chk("halted_no_reads", 16'(rd_count - rc0), 16'd0);
    chk("rst2_imem_rd", 16'(imem_bus.imem_rd), 16'h0);
    tick(); rst = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE;
    push_addr(16'h0000); push_fd(OPC_NOP, 16'h0000); #2;
    chk("restart_addr", imem_bus.imem_addr, 16'h0000);
    tick(); redirect = 1'b0; push_addr(16'hFFFE); push_fd(16'hA5FE, 16'h0000); #2;
    chk("wrap_inc_pc", inc_pc, 16'h0000);
    tick(); push_addr(16'h0000); push_fd(16'h1111, 16'h0002); #2;
    chk("wrap_next_addr", imem_bus.imem_addr, 16'h0000);
    tick(); rst = 1'b1;
    tick();
    chk("fd_queue_drained", 16'(exp_fd.size()), 16'h0);
    chk("addr_queue_drained", 16'(exp_addr.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
